// File: rtl/mac_job_scheduler.sv
// Round-robin scheduler sharing one never-clearing mac_core accumulator among N_REQ requesters.
// Each job snapshots the accumulator, streams BURST_LEN words and returns end-base.
module mac_job_scheduler #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_data,
    input  logic [N_REQ-1:0]     req_data_valid,
    output logic [N_REQ-1:0]     req_data_ready,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ack,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [15:0]          mac_data_in,
    output logic                 mac_wr_en,
    output logic                 mac_rd_en,
    input  logic [15:0]          mac_data_out,
    input  logic                 mac_output_ready
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
    localparam int          NR = int'(N_REQ);

    typedef enum logic [2:0] {
        StIdle, StRdBase, StWaitBase, StStream, StSettle, StRdEnd, StWaitEnd, StResp
    } state_e;

    state_e          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   wait_cnt;
    logic [15:0]     base;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [15:0]     own_data;
    logic            own_valid;
    logic            own_ack;
    logic            stream_open;
    logic            accept;
    logic            wait_expired;

    // Search starts one past the last served requester and wraps around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        for (int k = 1; k <= NR; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pick_found && req[i] && ((int'(rr_ptr) + k) % NR == i)) begin
                    pick_found = 1'b1;
                    pick_idx   = IW'(i);
                    pick_oh[i] = 1'b1;
                end
            end
        end
    end

    assign stream_open = (state == StStream) && (cnt < CW'(BURST_LEN));

    always_comb begin
        own_data       = '0;
        own_valid      = 1'b0;
        own_ack        = 1'b0;
        req_data_ready = '0;
        for (int i = 0; i < NR; i++) begin
            if (gidx == IW'(i)) begin
                own_data          = req_data[16*i +: 16];
                own_valid         = req_data_valid[i];
                own_ack           = rsp_ack[i];
                req_data_ready[i] = stream_open;
            end
        end
    end

    assign accept       = stream_open && own_valid;
    assign wait_expired = (wait_cnt == TW'(RD_TIMEOUT - 1));
    assign busy         = (state != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            rr_ptr      <= IW'(N_REQ - 1);
            gidx        <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            base        <= '0;
            grant       <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            mac_data_in <= '0;
            mac_wr_en   <= 1'b0;
            mac_rd_en   <= 1'b0;
        end else begin
            mac_wr_en <= 1'b0;
            mac_rd_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pick_found) begin
                        gidx      <= pick_idx;
                        grant     <= pick_oh;
                        cnt       <= '0;
                        wait_cnt  <= '0;
                        mac_rd_en <= 1'b1;
                        state     <= StRdBase;
                    end
                end
                StRdBase: state <= StWaitBase;
                StWaitBase: begin
                    if (mac_output_ready) begin
                        base  <= mac_data_out;
                        state <= StStream;
                    end else if (wait_expired) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant;
                        state     <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StStream: begin
                    if (accept) begin
                        mac_wr_en   <= 1'b1;
                        mac_data_in <= own_data;
                        cnt         <= cnt + 1'b1;
                        if (cnt == CW'(BURST_LEN - 1)) state <= StSettle;
                    end
                end
                // Last write lands in the accumulator before the closing read is issued.
                StSettle: begin
                    wait_cnt  <= '0;
                    mac_rd_en <= 1'b1;
                    state     <= StRdEnd;
                end
                StRdEnd: state <= StWaitEnd;
                StWaitEnd: begin
                    if (mac_output_ready) begin
                        rsp_data  <= mac_data_out - base;
                        rsp_err   <= 1'b0;
                        rsp_valid <= grant;
                        state     <= StResp;
                    end else if (wait_expired) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant;
                        state     <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (own_ack) begin
                        rr_ptr    <= gidx;
                        grant     <= '0;
                        rsp_valid <= '0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Bench for mac_job_scheduler with a behavioural accumulator standing in for mac_core.
// Expected job results are queued by the stimulus and checked by an independent monitor.
module tb_mac_job_scheduler;

    typedef logic [15:0] words_t [4];
    typedef struct {
        logic [1:0]  owner;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_data_valid = '0;
    logic [1:0]  req_data_ready;
    logic [1:0]  grant;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ack = '0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] mac_data_in;
    logic        mac_wr_en;
    logic        mac_rd_en;
    logic [15:0] mac_data_out = '0;
    logic        mac_output_ready = 1'b0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   wr_total = 0;
    int   overlap = 0;
    exp_t exp_q[$];

    logic [15:0] acc = '0;
    logic        rd_pipe = 1'b0;
    logic        block_ready = 1'b0;
    logic        prev_valid = 1'b0;

    mac_job_scheduler #(.N_REQ(2), .BURST_LEN(4), .RD_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .req_data_valid(req_data_valid), .req_data_ready(req_data_ready), .grant(grant),
        .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mac_data_in(mac_data_in), .mac_wr_en(mac_wr_en), .mac_rd_en(mac_rd_en),
        .mac_data_out(mac_data_out), .mac_output_ready(mac_output_ready)
    );

    always #5 clk = ~clk;

    // Accumulator model: read result appears two cycles after rd_en, never cleared.
    always @(posedge clk) begin
        if (mac_wr_en) acc <= acc + mac_data_in;
        rd_pipe          <= mac_rd_en;
        mac_output_ready <= rd_pipe && !block_ready;
        mac_data_out     <= acc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rising rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (mac_wr_en) wr_total++;
        if (mac_wr_en && mac_rd_en) overlap++;
        if (reset_n && (rsp_valid != 2'b00) && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid %b, required none", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", 32'(rsp_valid), 32'(e.owner));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        prev_valid = |rsp_valid;
    end

    task automatic push_exp(input int idx, input logic [15:0] d, input logic err);
        exp_t e;
        e.owner = 2'(1) << idx;
        e.data  = d;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input logic [1:0] exp);
        int c = 0;
        while (grant == 2'b00 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("grant", 32'(grant), 32'(exp));
        check("busy_job", 32'(busy), 32'd1);
    endtask

    task automatic stream(input int idx, input words_t w, input int nwords,
                          input logic [6:0] pat, input int plen);
        int   k = 0;
        int   pi = 0;
        int   cyc = 0;
        logic v;
        logic acc_now;
        logic [1:0] oh;
        oh = 2'(1) << idx;
        while (k < nwords && cyc < 100) begin
            v = (pi < plen) ? pat[pi] : 1'b1;
            if (idx == 0) req_data[15:0] = w[k];
            else req_data[31:16] = w[k];
            req_data_valid = v ? oh : 2'b00;
            #1;
            acc_now = v && ((req_data_ready & oh) != 2'b00);
            @(negedge clk);
            if (acc_now) k++;
            if (!v || acc_now) pi++;
            cyc++;
        end
        req_data_valid = '0;
        check("stream_accepts", 32'(k), 32'(nwords));
    endtask

    task automatic finish_resp(input int idx, input bit try_other);
        int c = 0;
        logic [1:0] oh;
        oh = 2'(1) << idx;
        while ((rsp_valid & oh) == 2'b00 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("rsp_seen", 32'(rsp_valid), 32'(oh));
        if (try_other) begin
            rsp_ack = ~oh;
            @(negedge clk);
            rsp_ack = '0;
            check("nonowner_ack_ignored", 32'(rsp_valid), 32'(oh));
        end
        rsp_ack = oh;
        @(negedge clk);
        rsp_ack = '0;
        check("ack_clears", 32'({grant, rsp_valid, 3'b0, busy}), 32'd0);
    endtask

    task automatic job(input int idx, input logic [1:0] keep, input words_t w,
                       input logic [6:0] pat, input int plen, input logic [15:0] exp_d,
                       input bit try_other);
        logic [1:0] oh;
        int wr0;
        oh  = 2'(1) << idx;
        req = req | oh;
        wait_grant(oh);
        req = req & keep & ~oh;
        wr0 = wr_total;
        stream(idx, w, 4, pat, plen);
        check("ready_after_last", 32'(req_data_ready), 32'd0);
        push_exp(idx, exp_d, 1'b0);
        finish_resp(idx, try_other);
        check("wr_pulses", 32'(wr_total - wr0), 32'd4);
    endtask

    initial begin
        words_t w;
        int c;
        int wr0;
        repeat (3) @(negedge clk);
        check("reset_ctrl",
              32'({grant, rsp_valid, req_data_ready, rsp_err, busy, mac_wr_en, mac_rd_en}), 0);
        check("reset_data", 32'({rsp_data, mac_data_in}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1/2: basic sum, then wrap against a nonzero base.
        w = '{16'd1, 16'd2, 16'd3, 16'd4};
        job(0, 2'b00, w, 7'h7f, 0, 16'h000A, 1'b1);
        w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        job(1, 2'b00, w, 7'h7f, 0, 16'hFFFC, 1'b0);

        // Test 3: simultaneous requests after reset, then round-robin.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req = 2'b11;
        w = '{16'd1, 16'd2, 16'd3, 16'd4};
        job(0, 2'b10, w, 7'h7f, 0, 16'h000A, 1'b0);
        w = '{16'd2, 16'd2, 16'd2, 16'd2};
        job(1, 2'b00, w, 7'h7f, 0, 16'h0008, 1'b0);
        req = 2'b11;
        w = '{16'd1, 16'd1, 16'd1, 16'd1};
        job(0, 2'b00, w, 7'h7f, 0, 16'h0004, 1'b0);

        // Test 4: valid gaps 1,0,0,1,1,0,1.
        w = '{16'd5, 16'd6, 16'd7, 16'd8};
        job(0, 2'b00, w, 7'b1011001, 7, 16'h001A, 1'b0);

        // Test 5: no read response -> timeout after 16 cycles in WAIT_BASE.
        block_ready = 1'b1;
        wr0 = wr_total;
        req = 2'b10;
        wait_grant(2'b10);
        req = 2'b00;
        push_exp(1, 16'h0000, 1'b1);
        c = 0;
        while (rsp_valid == 2'b00 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("timeout_latency", 32'(c), 32'd17);
        finish_resp(1, 1'b0);
        check("timeout_no_wr", 32'(wr_total - wr0), 32'd0);
        block_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Test 6: asynchronous reset two words into a burst, then a clean job.
        req = 2'b01;
        wait_grant(2'b01);
        req = 2'b00;
        w = '{16'd9, 16'd9, 16'd0, 16'd0};
        stream(0, w, 2, 7'h7f, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ctrl",
              32'({grant, rsp_valid, req_data_ready, rsp_err, busy, mac_wr_en, mac_rd_en}), 0);
        check("async_reset_data", 32'({rsp_data, mac_data_in}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        w = '{16'd1, 16'd1, 16'd1, 16'd1};
        job(0, 2'b00, w, 7'h7f, 0, 16'h0004, 1'b0);

        repeat (5) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wr_rd_overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
